if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_pkg.sv | 33 +++
 rtl/if_fifo.sv | 88 ++++++++
 rtl/if_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants, entry type and depth selection for the fetch stage
//
// Configuration macro: IF_PREFETCH_EN
//   defined   -> DEPTH = 2 (two-entry queue, up to two requests in flight)
//   undefined -> DEPTH = 1 (single entry, one request in flight)
package if_pkg;

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int INSTR_W = 17;
    localparam int PC_W    = 16;

    localparam logic [INSTR_W-1:0] NOOP_INSTR = 17'h00000;
    localparam logic [4:0]         HLT_OPC    = 5'b11111;
    localparam logic [PC_W-1:0]    RESET_PC   = 16'h0000;

    // One queued fetch result: the instruction and the PC that follows it.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    nxt_pc;
    } fetch_entry_t;

    // Opcode lives in the top five bits of the instruction word.
    function automatic logic is_hlt(input logic [INSTR_W-1:0] i);
        return i[INSTR_W-1 -: 5] == HLT_OPC;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - small flushable FIFO holding fetched instructions
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        empty the queue (wins over push and pop)
//   push_i         write push_data_i (ignored when full unless popping)
//   push_data_i    entry to write
//   pop_i          drop the head entry (ignored when empty)
//   full_o         queue holds DEPTH entries
//   empty_o        queue holds no entries
//   head_o         oldest entry (undefined content when empty)
//   count_o        current occupancy
module if_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 33,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    // Storage is sized to the full pointer range so every pointer value indexes a real slot.
    logic [W-1:0]     mem_q [2**PTR_W];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with in-order prefetch queue, redirect squash and halt
//
// Configuration macro: IF_PREFETCH_EN (selects DEPTH in if_pkg: 2 when defined, 1 otherwise)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_IM_ID         decode is not consuming this cycle
//   flow_change_ID_EX   taken branch/jump; redirect fetch to dst_ID_EX
//   dst_ID_EX           redirect target PC
//   im_req, im_addr     instruction-memory read request and word address
//   im_rdy              memory accepts the request this cycle
//   im_rvalid, im_rdata in-order read response
//   instr, nxt_pc       instruction presented to decode and its PC + 1
//   halted              fetch stopped after popping an HLT
module if_fetch
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_IM_ID,
    input  logic               flow_change_ID_EX,
    input  logic [PC_W-1:0]    dst_ID_EX,
    output logic               im_req,
    output logic [PC_W-1:0]    im_addr,
    input  logic               im_rdy,
    input  logic               im_rvalid,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    nxt_pc,
    output logic               halted
);

    logic [PC_W-1:0]  fpc_q, fpc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             halted_q, halted_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata, fifo_head;

    logic [CNT_W:0]   occ_sum;
    logic             accept;
    logic [PC_W-1:0]  resp_pc;

    // Requests plus queued entries may never exceed DEPTH, so every response has a slot.
    assign occ_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign im_req  = rst_n && !halted_q && !flow_change_ID_EX &&
                     (occ_sum < (CNT_W+1)'(DEPTH));
    assign im_addr = fpc_q;
    assign accept  = im_req && im_rdy;

    // Requests since the last redirect are sequential and responses are in order, so the
    // oldest live request sits inflight_q words behind fpc. Stale ones are already squashed
    // whenever this value is used.
    assign resp_pc = fpc_q - PC_W'(inflight_q);

    // The response arriving in a redirect cycle belongs to the old path and is dropped.
    assign fifo_push  = im_rvalid && (squash_q == '0) && !flow_change_ID_EX &&
                        (!fifo_full || fifo_pop);
    assign fifo_wdata = '{instr: im_rdata, nxt_pc: resp_pc + PC_W'(1)};
    assign fifo_pop   = !fifo_empty && !stall_IM_ID && !flow_change_ID_EX;

    assign instr   = (!fifo_empty && !flow_change_ID_EX) ? fifo_head.instr  : NOOP_INSTR;
    assign nxt_pc  = (!fifo_empty && !flow_change_ID_EX) ? fifo_head.nxt_pc : fpc_q;
    assign halted  = halted_q;

    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = inflight_q;
        squash_d   = squash_q;
        halted_d   = halted_q;

        if (flow_change_ID_EX) begin
            fpc_d = dst_ID_EX;
        end else if (accept) begin
            fpc_d = fpc_q + PC_W'(1);
        end

        case ({accept, im_rvalid})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        // On redirect every outstanding request is stale; the one returning now is
        // already being discarded, so it is not counted again.
        if (flow_change_ID_EX) begin
            if (im_rvalid && (inflight_q != '0)) begin
                squash_d = inflight_q - CNT_W'(1);
            end else begin
                squash_d = inflight_q;
            end
        end else if (im_rvalid && (squash_q != '0)) begin
            squash_d = squash_q - CNT_W'(1);
        end

        if (fifo_pop && is_hlt(fifo_head.instr)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            inflight_q <= '0;
            squash_q   <= '0;
            halted_q   <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            halted_q   <= halted_d;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flow_change_ID_EX),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule
